seg7_scroll_ctrl: RTL and testbench

- Parametrised scrolling-message controller for a multiplexed common-anode 7-segment display.
- The host loads a message into an internal character buffer, then starts a scroll. The block steps a NUM_DIGITS-wide window across the message at a programmable rate and time-multiplexes the digits.
- All timing is derived from one clock via enable ticks; there are no derived clocks.
- Supports wrap or one-shot mode, left/right direction, and pause.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_char_decoder.sv | 33 +++
 rtl/seg7_scroll_ctrl.sv | 109 ++++++++++
 tb/tb_seg7_scroll_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: character codes, active-low segment patterns and FSM states shared by the scroll controller
package seg7_pkg;
  localparam logic [4:0] CH_0 = 5'd0, CH_1 = 5'd1, CH_2 = 5'd2, CH_3 = 5'd3, CH_4 = 5'd4;
  localparam logic [4:0] CH_5 = 5'd5, CH_6 = 5'd6, CH_7 = 5'd7, CH_8 = 5'd8, CH_9 = 5'd9;
  localparam logic [4:0] CH_A = 5'd10, CH_H = 5'd11, CH_L = 5'd12, CH_R = 5'd13, CH_S = 5'd14;
  localparam logic [4:0] CH_T = 5'd15, CH_P = 5'd16, CH_U = 5'd17, CH_E = 5'd18, CH_MINUS = 5'd19;
  localparam logic [4:0] CH_BLANK = 5'd31;
  // {g,f,e,d,c,b,a}, a zero lights the segment
  localparam logic [6:0] SEG_0 = 7'h40, SEG_1 = 7'h79, SEG_2 = 7'h24, SEG_3 = 7'h30, SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12, SEG_6 = 7'h02, SEG_7 = 7'h78, SEG_8 = 7'h00, SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08, SEG_H = 7'h09, SEG_L = 7'h47, SEG_R = 7'h2F, SEG_S = 7'h12;
  localparam logic [6:0] SEG_T = 7'h07, SEG_P = 7'h0C, SEG_U = 7'h41, SEG_E = 7'h06, SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic {ST_IDLE, ST_SCROLL} state_t;
endpackage

// File: rtl/seg7_char_decoder.sv
// seg7_char_decoder: 5-bit character code to active-low segment pattern, unknown codes blank
module seg7_char_decoder
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] pattern
);
  always_comb begin
    case (code)
      CH_0: pattern = SEG_0;
      CH_1: pattern = SEG_1;
      CH_2: pattern = SEG_2;
      CH_3: pattern = SEG_3;
      CH_4: pattern = SEG_4;
      CH_5: pattern = SEG_5;
      CH_6: pattern = SEG_6;
      CH_7: pattern = SEG_7;
      CH_8: pattern = SEG_8;
      CH_9: pattern = SEG_9;
      CH_A: pattern = SEG_A;
      CH_H: pattern = SEG_H;
      CH_L: pattern = SEG_L;
      CH_R: pattern = SEG_R;
      CH_S: pattern = SEG_S;
      CH_T: pattern = SEG_T;
      CH_P: pattern = SEG_P;
      CH_U: pattern = SEG_U;
      CH_E: pattern = SEG_E;
      CH_MINUS: pattern = SEG_MINUS;
      default: pattern = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_scroll_ctrl.sv
// seg7_scroll_ctrl: scrolls a buffered message across a multiplexed common-anode 7-segment display
module seg7_scroll_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int NUM_DIGITS = 4,
  parameter int MSG_DEPTH = 32,
  parameter int STEP_CYCLES = 50000000,
  parameter int REFRESH_CYCLES = 65536,
  parameter int AW = $clog2(MSG_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [4:0]            wr_data,
  input  logic [AW:0]           msg_len,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode_wrap,
  input  logic                  dir,
  input  logic                  pause,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  done
);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(STEP_CYCLES);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam int IW = AW + 2;
  logic [4:0] mem [MSG_DEPTH];
  state_t state;
  logic [AW-1:0] pos, pos_next, rd_idx;
  logic [AW:0] len;
  logic wrap, rdir, tick, last, ref_last, blank;
  logic [SW-1:0] step_cnt;
  logic [RW-1:0] ref_cnt;
  logic [DW-1:0] dig;
  logic [IW-1:0] sum, div;
  logic [6:0] pattern;
  assign dp = 1'b1;
  always_ff @(posedge clock)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_comb begin
    tick = state == ST_SCROLL && !pause && step_cnt == SW'(STEP_CYCLES - 1);
    last = ({1'b0, pos} + (AW+1)'(1)) == len;
    pos_next = !wrap ? pos + AW'(1)
             : rdir ? (pos == '0 ? AW'(len - (AW+1)'(1)) : pos - AW'(1))
             : (last ? '0 : pos + AW'(1));
    ref_last = ref_cnt == RW'(REFRESH_CYCLES - 1);
    sum = IW'(pos) + IW'(NUM_DIGITS - 1) - IW'(dig);
    div = len == '0 ? IW'(1) : IW'(len);
    blank = state != ST_SCROLL || (!wrap && sum >= IW'(len));
    rd_idx = AW'(wrap ? sum % div : sum);
  end
  seg7_char_decoder u_dec (.code(mem[rd_idx]), .pattern(pattern));
  // an and seg come from the same registered digit index so they always switch together
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ref_cnt <= '0;
      dig <= DW'(NUM_DIGITS - 1);
      an <= '1;
      seg <= SEG_BLANK;
    end else begin
      ref_cnt <= ref_last ? '0 : ref_cnt + RW'(1);
      if (ref_last) dig <= dig == '0 ? DW'(NUM_DIGITS - 1) : dig - DW'(1);
      an <= state == ST_SCROLL ? ~(NUM_DIGITS'(1) << dig) : '1;
      seg <= blank ? SEG_BLANK : pattern;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      pos <= '0;
      len <= '0;
      wrap <= 1'b0;
      rdir <= 1'b0;
      step_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        busy <= 1'b0;
        step_cnt <= '0;
      end else if (start && msg_len != '0) begin
        state <= ST_SCROLL;
        busy <= 1'b1;
        pos <= '0;
        len <= msg_len;
        wrap <= mode_wrap;
        rdir <= dir;
        step_cnt <= '0;
      end else if (state == ST_IDLE) begin
        step_cnt <= '0;
      end else if (!pause) begin
        step_cnt <= tick ? '0 : step_cnt + SW'(1);
        if (tick && !wrap && last) begin
          state <= ST_IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end else if (tick) begin
          pos <= pos_next;
        end
      end
    end
endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// tb_seg7_scroll_ctrl: directed scroll scenarios; expected digit patterns are queued and
// checked by a monitor whenever the matching anode is lit
module tb_seg7_scroll_ctrl;
  localparam int ND = 4, MD = 16, SC = 8, RC = 2, AW = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic wr_en = 1'b0, start = 1'b0, stop = 1'b0, mode_wrap = 1'b0, dir = 1'b0, pause = 1'b1;
  logic [AW-1:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [AW:0] msg_len = '0;
  logic [6:0] seg;
  logic dp, busy, done;
  logic [ND-1:0] an;
  typedef struct packed {logic [ND-1:0] an; logic [6:0] seg;} exp_t;
  exp_t exp_q[$];
  string name_q[$];
  int n_chk = 0, n_pass = 0;
  seg7_scroll_ctrl #(.CLK_HZ(100000000), .NUM_DIGITS(ND), .MSG_DEPTH(MD), .STEP_CYCLES(SC),
    .REFRESH_CYCLES(RC), .AW(AW)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .stop(stop), .mode_wrap(mode_wrap), .dir(dir),
    .pause(pause), .seg(seg), .dp(dp), .an(an), .busy(busy), .done(done));
  always #5 clock = ~clock;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
  endtask
  function automatic logic [6:0] pat(int c);
    case (c)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;  4: return 7'h19;
      5: return 7'h12;  6: return 7'h02;  7: return 7'h78;  8: return 7'h00;  9: return 7'h10;
      10: return 7'h08; 11: return 7'h09; 12: return 7'h47; 13: return 7'h2F; 14: return 7'h12;
      15: return 7'h07; 16: return 7'h0C; 17: return 7'h41; 18: return 7'h06; 19: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction
  always @(negedge clock)
    if (exp_q.size() != 0 && an === exp_q[0].an) begin
      chk(name_q[0], 32'(seg), 32'(exp_q[0].seg));
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end
  task automatic tick_wait(int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask
  task automatic check_win(string nm, int c3, int c2, int c1, int c0);
    int codes[4];
    int t = 0;
    codes = '{c0, c1, c2, c3};
    tick_wait(2);
    for (int k = ND - 1; k >= 0; k--) begin
      exp_q.push_back('{an: ~(ND'(1) << k), seg: pat(codes[k])});
      name_q.push_back($sformatf("%s.d%0d", nm, k));
    end
    while (exp_q.size() != 0 && t < 40) begin tick_wait(1); t++; end
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL %s: scan timeout, %0d digits never shown", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask
  task automatic wr(int a, int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = 5'(d);
    tick_wait(1);
    wr_en = 1'b0;
  endtask
  task automatic go(int len, logic w, logic d);
    msg_len = (AW+1)'(len); mode_wrap = w; dir = d; start = 1'b1;
    tick_wait(1);
    start = 1'b0;
  endtask
  task automatic step(int n);
    pause = 1'b0;
    tick_wait(SC * n);
    pause = 1'b1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int msg1[13];
    int ndone, tdone;
    msg1 = '{14, 11, 10, 10, 14, 15, 13, 10, 31, 2, 0, 2, 1};
    tick_wait(3);
    @(negedge clock);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 13; i++) wr(i, msg1[i]);
    go(13, 1'b1, 1'b0);
    chk("wrap_busy", 32'(busy), 32'd1);
    check_win("wl_p0", 14, 11, 10, 10);
    step(1); check_win("wl_p1", 11, 10, 10, 14);
    step(1); check_win("wl_p2", 10, 10, 14, 15);
    pause = 1'b0; tick_wait(3); pause = 1'b1;
    tick_wait(40);
    check_win("pause_hold", 10, 10, 14, 15);
    pause = 1'b0; tick_wait(5); pause = 1'b1;
    check_win("pause_resume", 10, 14, 15, 13);
    step(8); check_win("wl_p11", 2, 1, 14, 11);
    step(1); check_win("wl_p12", 1, 14, 11, 10);
    step(1); check_win("wl_wrap", 14, 11, 10, 10);
    chk("wrap_busy_after", 32'(busy), 32'd1);
    go(13, 1'b1, 1'b1);
    check_win("wr_p0", 14, 11, 10, 10);
    step(1); check_win("wr_p12", 1, 14, 11, 10);
    step(1); check_win("wr_p11", 2, 1, 14, 11);
    stop = 1'b1; tick_wait(1); stop = 1'b0;
    tick_wait(2);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_an", 32'(an), 32'hF);
    go(0, 1'b1, 1'b0);
    tick_wait(2);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_an", 32'(an), 32'hF);
    wr(0, 11); wr(1, 18); wr(2, 12); wr(3, 16);
    go(4, 1'b0, 1'b0);
    check_win("os_p0", 11, 18, 12, 16);
    step(1); check_win("os_p1", 18, 12, 16, 31);
    step(1); check_win("os_p2", 12, 16, 31, 31);
    step(1); check_win("os_p3", 16, 31, 31, 31);
    step(1);
    chk("os_done", 32'(done), 32'd1);
    chk("os_busy", 32'(busy), 32'd0);
    pause = 1'b0;
    go(4, 1'b0, 1'b0);
    ndone = 0; tdone = 0;
    for (int c = 1; c <= 50; c++) begin
      tick_wait(1);
      if (done) begin ndone++; tdone = c; end
    end
    chk("done_count", 32'(ndone), 32'd1);
    chk("done_cycle", 32'(tdone), 32'd32);
    chk("os_end_an", 32'(an), 32'hF);
    chk("os_end_busy", 32'(busy), 32'd0);
    go(4, 1'b1, 1'b0);
    tick_wait(3);
    chk("ss_busy_pre", 32'(busy), 32'd1);
    start = 1'b1; stop = 1'b1;
    tick_wait(1);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", 32'(busy), 32'd0);
    tick_wait(2);
    chk("ss_an", 32'(an), 32'hF);
    pause = 1'b1;
    go(4, 1'b1, 1'b0);
    check_win("pre_wr27", 11, 18, 12, 16);
    wr(1, 27);
    check_win("wr27", 11, 31, 12, 16);
    pause = 1'b0;
    tick_wait(5);
    chk("rst_mid_busy_pre", 32'(busy), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_seg", 32'(seg), 32'h7F);
    chk("rst_mid_an", 32'(an), 32'hF);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    tick_wait(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
